mmss_down_timer: RTL
====================

// Module: mmss_down_timer
// PURPOSE
//  Parametrised four-digit BCD countdown timer (MM:SS), successor to the single mod-6 tens-of-seconds digit.
//  Chains sec_ones (mod 10), sec_tens (mod 6), min_ones (mod 10) and min_tens (mod MIN_TENS_MOD).
//  Adds an on-chip prescaler, load validation, stop-at-zero and an optional auto-reload mode.
//  Feeds the display driver and the magnetron-enable control of the microwave.
// PARAMETERS
//  TICK_DIV      50_000_000  clock cycles per 1 s decrement tick (>=1)
//  MIN_TENS_MOD  10          modulus of the min_tens digit (2..10); max load = MIN_TENS_MOD-1
//  AUTO_RELOAD   0           1: on reaching 00:00 reload the last loaded value and keep counting
// PORTS
//  clock     in   1   rising-edge clock
//  clear     in   1   synchronous, active-high reset
//  loadn     in   1   active-low synchronous load of data
//  en        in   1   count enable (0 = pause; prescaler holds)
//  data      in   16  {min_tens,min_ones,sec_tens,sec_ones} BCD load value
//  time_bcd  out  16  current value, same packing as data
//  zero      out  1   level: time_bcd == 16'h0000
//  tc        out  1   one-cycle pulse on each countdown expiry
//  running   out  1   level: en && !zero (AUTO_RELOAD=1: en && reload value != 0)
// BEHAVIOUR
//  - Reset (clear=1 at edge): time_bcd=0, reload_reg=0, prescaler=0, tc=0, zero=1, running=0.
//  - Priority at each edge: clear > load (loadn=0) > count.
//  - Load: each digit is clamped before storage: ones digits >9 -> 9, sec_tens >5 -> 5, and
//    min_tens >MIN_TENS_MOD-1 -> MIN_TENS_MOD-1.
//    The clamped value goes to time_bcd and reload_reg. The prescaler clears to 0 and tc=0.
//    The value is visible the cycle after the load edge. Loading 0 sets zero=1 and does not pulse tc.
//  - Prescaler: increments when en=1 and the counter is not halted. It wraps from TICK_DIV-1 to 0,
//    and the wrap edge is the tick. The tick decrements time_bcd at that same edge.
//    en=0 freezes the prescaler (pause/resume keeps the partial second).
//  - Decrement: sec_ones-1. On a borrow (digit was 0) the digit becomes its modulus-1 and the
//    borrow ripples upward, e.g. 10:00 -> 09:59 in one tick.
//  - Expiry (tick while time_bcd==00:01):
//      AUTO_RELOAD=0: time_bcd -> 0000, zero=1 and tc=1 for exactly the following cycle.
//        The counter then halts: no further ticks, prescaler held at 0, even with en=1.
//      AUTO_RELOAD=1: time_bcd -> reload_reg, tc=1 for one cycle, zero stays 0, and counting continues.
//  - Halted at 00:00: only clear or load leaves this state. tc never repeats while halted.
//  - Load and tick on the same edge: the load wins and the tick is discarded.
//  - clear mid-count: the next cycle shows the reset values, and reload_reg is lost.
//  - tc, zero and running are registered (or decoded from registers) and glitch-free.
//    There is no combinational path from inputs to outputs.
//  - time_bcd never holds an invalid BCD digit, whatever data is applied.
// TESTING  (bench uses TICK_DIV=4, MIN_TENS_MOD=10 unless stated)
//  1. clear, then loadn=0 with data=16'h0012, then en=1.
//     -> time_bcd steps 0012, 0011 ... 0001 every 4 cycles, then 0000.
//     -> tc high for 1 cycle and zero=1; time_bcd stays 0000 for 20 more cycles.
//  2. Load 16'h1000, en=1.
//     -> after 4 cycles time_bcd=16'h0959 (full borrow chain).
//  3. Load 16'hFF7F.
//     -> time_bcd=16'h9959 (clamped).
//     -> With MIN_TENS_MOD=6: time_bcd=16'h5959.
//  4. Load 0005, en=1 for 2 cycles, en=0 for 10 cycles, then en=1.
//     -> the next decrement occurs 2 cycles after resume; time_bcd=0004.
//  5. AUTO_RELOAD=1: load 0002, en=1.
//     -> the sequence 0002, 0001, then 0002 repeats, with tc pulsing at each reload and zero never high.
//  6. Mid-count at 0007: assert clear for 1 cycle.
//     -> time_bcd=0000, zero=1, tc=0.
//     -> Load and tick on the same edge: the loaded value appears with no decrement.

Source files
------------

// File: rtl/mmss_down_timer.sv
// Four-digit BCD MM:SS countdown timer with an on-chip 1 s prescaler.
// Loads are clamped per digit, and the count halts at 00:00 or reloads, depending on AUTO_RELOAD.
module mmss_down_timer #(
    parameter int TICK_DIV     = 50_000_000,
    parameter int MIN_TENS_MOD = 10,
    parameter int AUTO_RELOAD  = 0
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        loadn,
    input  logic        en,
    input  logic [15:0] data,
    output logic [15:0] time_bcd,
    output logic        zero,
    output logic        tc,
    output logic        running
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [15:0]   time_reg, time_next;
    logic [15:0]   reload_reg, reload_next;
    logic [PW-1:0] presc_reg, presc_next;
    logic          tc_reg, tc_next;
    logic          running_reg, running_next;

    logic [15:0] load_value;
    logic [15:0] dec_value;
    logic [3:0]  borrow;
    logic        halted;

    assign borrow[0] = 1'b1;

    // Per-digit clamp on load and borrow-chain decrement; each digit has its own modulus.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            localparam logic [3:0] DIGIT_MAX =
                4'((gi == 3) ? (MIN_TENS_MOD - 1) : ((gi == 1) ? 5 : 9));
            logic [3:0] din;
            logic [3:0] cur;

            assign din = data[gi*4 +: 4];
            assign cur = time_reg[gi*4 +: 4];
            assign load_value[gi*4 +: 4] = (din > DIGIT_MAX) ? DIGIT_MAX : din;
            assign dec_value[gi*4 +: 4]  = !borrow[gi] ? cur :
                                           (cur == 4'd0) ? DIGIT_MAX : (cur - 4'd1);
            if (gi < 3) begin : g_borrow
                assign borrow[gi+1] = borrow[gi] && (cur == 4'd0);
            end
        end
    endgenerate

    // With auto-reload, 00:00 is only reachable when the reload value is 00:00 itself.
    assign halted = (time_reg == 16'h0000);

    always_comb begin
        time_next   = time_reg;
        reload_next = reload_reg;
        presc_next  = presc_reg;
        tc_next     = 1'b0;
        if (!loadn) begin
            time_next   = load_value;
            reload_next = load_value;
            presc_next  = '0;
        end else if (en && !halted) begin
            if (presc_reg == PRESC_LAST) begin
                presc_next = '0;
                if (time_reg == 16'h0001) begin
                    tc_next   = 1'b1;
                    time_next = (AUTO_RELOAD != 0) ? reload_reg : 16'h0000;
                end else begin
                    time_next = dec_value;
                end
            end else begin
                presc_next = presc_reg + 1'b1;
            end
        end
        running_next = en && ((AUTO_RELOAD != 0) ? (reload_next != 16'h0000)
                                                  : (time_next != 16'h0000));
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            time_reg    <= 16'h0000;
            reload_reg  <= 16'h0000;
            presc_reg   <= '0;
            tc_reg      <= 1'b0;
            running_reg <= 1'b0;
        end else begin
            time_reg    <= time_next;
            reload_reg  <= reload_next;
            presc_reg   <= presc_next;
            tc_reg      <= tc_next;
            running_reg <= running_next;
        end
    end

    assign time_bcd = time_reg;
    assign zero     = (time_reg == 16'h0000);
    assign tc       = tc_reg;
    assign running  = running_reg;

endmodule
